// File: rtl/io_timer_pkg.sv
// io_timer_pkg: register map and bit positions shared by the io_timer block
package io_timer_pkg;
  typedef enum logic [2:0] {
    REG_CTRL      = 3'd0,
    REG_STATUS    = 3'd1,
    REG_RELOAD_LO = 3'd2,
    REG_RELOAD_HI = 3'd3,
    REG_COUNT_LO  = 3'd4,
    REG_COUNT_HI  = 3'd5,
    REG_PRESCALE  = 3'd6,
    REG_NONE      = 3'd7
  } reg_e;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;
  localparam int STAT_EXP  = 0;
  localparam int STAT_RUN  = 1;
endpackage

// File: rtl/io_timer_prescaler.sv
// io_timer_prescaler: 8-bit tick divider, compiled only with IO_TIMER_PRESCALER_EN
`ifdef IO_TIMER_PRESCALER_EN
module io_timer_prescaler (
  input  logic       clk,
  input  logic       resetb,
  input  logic       en,
  input  logic       restart,
  input  logic [7:0] limit,
  output logic       tick
);
  logic [7:0] cnt;
  assign tick = en && cnt >= limit;
  // count 0..limit while enabled, one tick per wrap; restart realigns on timer start
  always_ff @(posedge clk)
    if (!resetb || restart) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 8'd1;
endmodule
`endif

// File: rtl/io_timer.sv
// io_timer: 16-bit down-counting timer with IRQ on one I/O select slot; IO_TIMER_PRESCALER_EN adds the prescaler
module io_timer
  import io_timer_pkg::*;
(
  input  logic       SYSCLK,
  input  logic       RESETB,
  input  logic       CSB,
  input  logic       RDB,
  input  logic       WRB,
  input  logic [2:0] A,
  input  logic [7:0] DB_IN,
  output logic [7:0] DB_OUT,
  output logic       DB_OE,
  output logic       IRQB
);
  logic        csb_q, wrb_q, rdb_q;
  logic [2:0]  a_q;
  logic [7:0]  db_q;
  logic        en, auto_rl, ie, exp_f;
  logic [15:0] reload, count;
  logic [7:0]  hi_latch;
  logic        tick, commit, ctrl_wr, stat_wr, start, expire, load;
  assign commit  = !wrb_q && WRB && !csb_q;
  assign ctrl_wr = commit && a_q == REG_CTRL;
  assign stat_wr = commit && a_q == REG_STATUS;
  assign start   = ctrl_wr && db_q[CTRL_EN] && !en;
  assign expire  = tick && count == '0;
  assign load    = start || (expire && (auto_rl || (ctrl_wr && db_q[CTRL_EN])));
  assign DB_OE   = !CSB && !RDB;
`ifdef IO_TIMER_PRESCALER_EN
  logic [7:0] prescale;
  // prescale register
  always_ff @(posedge SYSCLK)
    if (!RESETB) prescale <= '0;
    else if (commit && a_q == REG_PRESCALE) prescale <= db_q;
  io_timer_prescaler u_prescaler (
    .clk     (SYSCLK),
    .resetb  (RESETB),
    .en      (en),
    .restart (start),
    .limit   (prescale),
    .tick    (tick)
  );
`else
  assign tick = en;
`endif
  // strobe history and capture of the address/data seen while the write strobe is low
  always_ff @(posedge SYSCLK)
    if (!RESETB) begin
      csb_q <= 1'b1;
      wrb_q <= 1'b1;
      rdb_q <= 1'b1;
      a_q   <= '0;
      db_q  <= '0;
    end else begin
      csb_q <= CSB;
      wrb_q <= WRB;
      rdb_q <= RDB;
      if (!WRB && !CSB) begin
        a_q  <= A;
        db_q <= DB_IN;
      end
    end
  // control, reload and count; a CTRL write overrides the expiry's effect on EN
  always_ff @(posedge SYSCLK)
    if (!RESETB) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      reload  <= '0;
      count   <= '0;
    end else begin
      if (ctrl_wr) begin
        en      <= db_q[CTRL_EN];
        auto_rl <= db_q[CTRL_AUTO];
        ie      <= db_q[CTRL_IE];
      end else if (expire && !auto_rl) en <= 1'b0;
      if (commit && a_q == REG_RELOAD_LO) reload[7:0] <= db_q;
      if (commit && a_q == REG_RELOAD_HI) reload[15:8] <= db_q;
      if (load) count <= reload;
      else if (tick && count != '0) count <= count - 16'd1;
    end
  // expired flag (set beats clear), coherent high-byte latch and registered interrupt
  always_ff @(posedge SYSCLK)
    if (!RESETB) begin
      exp_f    <= 1'b0;
      hi_latch <= '0;
      IRQB     <= 1'b1;
    end else begin
      exp_f <= expire || (exp_f && !(stat_wr && db_q[STAT_EXP]));
      if (!CSB && !RDB && rdb_q && A == REG_COUNT_LO) hi_latch <= count[15:8];
      IRQB <= !(exp_f && ie);
    end
  // combinational read mux
  always_comb begin
    DB_OUT = '0;
    case (A)
      REG_CTRL: begin
        DB_OUT[CTRL_EN]   = en;
        DB_OUT[CTRL_AUTO] = auto_rl;
        DB_OUT[CTRL_IE]   = ie;
      end
      REG_STATUS: begin
        DB_OUT[STAT_EXP] = exp_f;
        DB_OUT[STAT_RUN] = en;
      end
      REG_RELOAD_LO: DB_OUT = reload[7:0];
      REG_RELOAD_HI: DB_OUT = reload[15:8];
      REG_COUNT_LO:  DB_OUT = count[7:0];
      REG_COUNT_HI:  DB_OUT = hi_latch;
`ifdef IO_TIMER_PRESCALER_EN
      REG_PRESCALE:  DB_OUT = prescale;
`endif
      default:       DB_OUT = '0;
    endcase
  end
endmodule

// File: tb/tb_io_timer.sv
// tb_io_timer: randomized scoreboard bench for io_timer against a cycle-arithmetic timer model
module tb_io_timer;
  logic       SYSCLK = 1'b0;
  logic       RESETB = 1'b0;
  logic       CSB = 1'b1;
  logic       RDB = 1'b1;
  logic       WRB = 1'b1;
  logic [2:0] A = 3'd0;
  logic [7:0] DB_IN = 8'd0;
  logic [7:0] DB_OUT;
  logic       DB_OE;
  logic       IRQB;

  io_timer dut (
    .SYSCLK (SYSCLK),
    .RESETB (RESETB),
    .CSB    (CSB),
    .RDB    (RDB),
    .WRB    (WRB),
    .A      (A),
    .DB_IN  (DB_IN),
    .DB_OUT (DB_OUT),
    .DB_OE  (DB_OE),
    .IRQB   (IRQB)
  );

  always #5 SYSCLK = ~SYSCLK;

  longint cyc = 0;
  always @(posedge SYSCLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
    logic       irq;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic oe_q = 1'b0;

  // reference model: a run started at edge c0 with reload R and prescale P ticks at
  // c0+k*(P+1) and expires at c0+k*(R+1)*(P+1); values are "state after edge t"
  bit         run, ctrl_auto, exp_st, ie, ie_old;
  longint     c0, since, ie_cc;
  int         R, P, cnt_fz;
  logic [7:0] reload_lo, reload_hi, prescale, hi_latch;

  function automatic longint period();
    return longint'(R + 1) * longint'(P + 1);
  endfunction

  function automatic bit en_at(longint t);
    return run && (ctrl_auto || t < c0 + period());
  endfunction

  function automatic int count_at(longint t);
    longint n;
    if (!run) return cnt_fz;
    n = (t - c0) / (P + 1);
    if (ctrl_auto) return R - int'(n % (R + 1));
    return (n > R) ? 0 : R - int'(n);
  endfunction

  function automatic bit exp_at(longint t);
    longint k;
    if (exp_st) return 1'b1;
    if (!run) return 1'b0;
    k = (t - c0) / period();
    if (!ctrl_auto && k > 1) k = 1;
    return k >= 1 && c0 + k * period() >= since;
  endfunction

  function automatic bit ie_at(longint t);
    return (t >= ie_cc) ? ie : ie_old;
  endfunction

  task automatic model_reset();
    run = 0; ctrl_auto = 0; exp_st = 0; ie = 0; ie_old = 0;
    c0 = 0; since = 0; ie_cc = 0; R = 0; P = 0; cnt_fz = 0;
    reload_lo = 0; reload_hi = 0; prescale = 0; hi_latch = 0;
  endtask

  task automatic model_wr(input logic [2:0] a, input logic [7:0] d, input longint cc);
    case (a)
      3'd0: begin
        if (!d[0]) begin
          if (run) begin
            cnt_fz = count_at(cc);
            exp_st = exp_at(cc);
            run = 0;
          end
        end else begin
          exp_st = exp_at(cc);
          run = 1; c0 = cc; since = cc;
          R = int'({reload_hi, reload_lo});
          P = int'(prescale);
        end
        ctrl_auto = d[1];
        ie_old = ie; ie = d[2]; ie_cc = cc;
      end
      3'd1: if (d[0]) begin exp_st = 0; since = cc; end
      3'd2: reload_lo = d;
      3'd3: reload_hi = d;
`ifdef IO_TIMER_PRESCALER_EN
      3'd6: prescale = d;
`endif
      default: ;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge SYSCLK);
      #1;
    end
  endtask

  task automatic chk_irq();
    chk("irqb_now", 32'(IRQB), 32'(!(exp_at(cyc - 1) && ie_at(cyc - 1))));
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    CSB = 1'b0; WRB = 1'b0; A = a; DB_IN = d;
    idle(4);
    WRB = 1'b1; CSB = 1'b1; A = 3'($urandom); DB_IN = 8'($urandom);
    idle(1);
    model_wr(a, d, cyc);
    idle(1);
  endtask

  task automatic rd(input logic [2:0] a);
    exp_t   e;
    longint n;
    int     c;
    n = cyc;
    c = count_at(n);
    e.a = a;
    e.irq = !(exp_at(n - 1) && ie_at(n - 1));
    case (a)
      3'd0: e.d = {5'b0, ie_at(n), ctrl_auto, en_at(n)};
      3'd1: e.d = {6'b0, en_at(n), exp_at(n)};
      3'd2: e.d = reload_lo;
      3'd3: e.d = reload_hi;
      3'd4: begin e.d = c[7:0]; hi_latch = c[15:8]; end
      3'd5: e.d = hi_latch;
      3'd6: e.d = prescale;
      default: e.d = 8'd0;
    endcase
    sb.push_back(e);
    CSB = 1'b0; RDB = 1'b0; A = a;
    idle(4);
    CSB = 1'b1; RDB = 1'b1;
    idle(1);
  endtask

  // monitor: each new read-drive window pops one expectation
  always @(negedge SYSCLK) begin
    if (DB_OE && !oe_q) begin
      if (sb.size() == 0) chk("unexpected_read", 32'(DB_OUT), 32'hFFFF_FFFF);
      else begin
        mon_e = sb.pop_front();
        chk($sformatf("rd%0d_data", mon_e.a), 32'(DB_OUT), 32'(mon_e.d));
        chk($sformatf("rd%0d_irqb", mon_e.a), 32'(IRQB), 32'(mon_e.irq));
      end
    end
    oe_q <= DB_OE;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d reads pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    longint e;
    longint k;
    model_reset();
    idle(2);
    RESETB = 1'b1;
    chk("reset_oe", 32'(DB_OE), 32'd0);
    chk("reset_dbout", 32'(DB_OUT), 32'd0);
    chk("reset_irqb", 32'(IRQB), 32'd1);
    idle(1);
    for (int i = 0; i < 8; i++) rd(3'(i));

    wr(3'd2, 8'h03); wr(3'd3, 8'h00); wr(3'd6, 8'h00);
    for (int d = 3; d <= 5; d++) begin
      wr(3'd1, 8'h01);
      wr(3'd0, 8'h05);
      idle(d - 1);
      rd(3'd1);
      idle(4);
      rd(3'd1); rd(3'd0); rd(3'd4);
      chk_irq();
    end

    wr(3'd2, 8'h01); wr(3'd6, 8'h02); wr(3'd1, 8'h01);
    wr(3'd0, 8'h03);
    for (int i = 0; i < 6; i++) begin
      rd(3'd1);
      idle(i % 3);
      if (i == 3) wr(3'd1, 8'h01);
    end
    wr(3'd0, 8'h00);
    rd(3'd0); rd(3'd4);

    wr(3'd2, 8'h01); wr(3'd3, 8'h01); wr(3'd6, 8'h00);
    wr(3'd0, 8'h01);
    rd(3'd4); rd(3'd5);
    wr(3'd0, 8'h00);
    rd(3'd4); rd(3'd5);

    wr(3'd6, 8'h05);
    rd(3'd6);
    wr(3'd6, 8'h00);

    wr(3'd2, 8'h02); wr(3'd3, 8'h00);
    wr(3'd0, 8'h07);
    for (int i = 0; i < 2; i++) begin
      k = (cyc + 5 - c0 + period() - 1) / period();
      e = c0 + k * period();
      idle(int'(e - 5 - cyc));
      wr(3'd1, 8'h01);
      chk_irq();
      rd(3'd1);
    end

    CSB = 1'b0; WRB = 1'b0; A = 3'd2; DB_IN = 8'hAA;
    idle(2);
    RESETB = 1'b0;
    idle(1);
    WRB = 1'b1; CSB = 1'b1;
    idle(1);
    RESETB = 1'b1;
    model_reset();
    chk_irq();
    idle(1);
    rd(3'd2); rd(3'd0); rd(3'd1); rd(3'd4); rd(3'd3);

    for (int i = 0; i < 220; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (en_at(cyc + 4)) begin
        if (op < 3) wr(3'd1, 8'($urandom));
        else if (op < 5) wr(3'd0, 8'($urandom) & 8'hFE);
        else if (op < 8) rd(3'($urandom_range(0, 7)));
        else idle(int'($urandom_range(1, 6)));
      end else begin
        case (op)
          0, 1: rd(3'($urandom_range(0, 7)));
          2, 3: wr(3'd0, 8'($urandom));
          4: wr(3'd1, 8'($urandom));
          5: wr(3'd2, 8'($urandom_range(0, 12)));
          6: wr(3'd3, ($urandom_range(0, 5) == 0) ? 8'd1 : 8'd0);
          7: wr(3'd6, 8'($urandom_range(0, 3)));
          8: wr(3'($urandom_range(4, 7)), 8'($urandom));
          default: idle(int'($urandom_range(1, 8)));
        endcase
      end
      chk_irq();
    end

    idle(3);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
